note_event_tracker: RTL

- Consumes the per-FFT-frame note index stream from note_lookup and debounces it into stable notes.
- Measures each stable note's length in metronome eighth-note ticks and quantises it to eighth, quarter, half or whole.
- Queues {note, duration} events in a small FIFO for the score renderer (image_sprite) to pop with a valid/ready handshake.
- Sits between note_lookup and the display path, in the clk_m domain.

---
 rtl/note_event_pkg.sv | 41 ++++
 rtl/note_event_tracker_fifo.sv | 77 +++++++
 rtl/note_event_tracker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/note_event_pkg.sv
// note_event_pkg
// Shared types for the note event tracker slice:
//   dur_t          - quantised note length code
//   track_state_t  - tracker FSM state
//   note_event_t   - {note, duration} record queued for the renderer
//   quantise_dur() - maps an eighth-tick count onto a duration code
package note_event_pkg;

    typedef enum logic [1:0] {
        DUR_EIGHTH  = 2'd0,
        DUR_QUARTER = 2'd1,
        DUR_HALF    = 2'd2,
        DUR_WHOLE   = 2'd3
    } dur_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } track_state_t;

    localparam logic [5:0] REST_NOTE = 6'd0;

    typedef struct packed {
        logic [5:0] note;
        dur_t       dur;
    } note_event_t;

    // 1 -> eighth, 2..3 -> quarter, 4..7 -> half, 8+ -> whole.
    // A count of 0 never reaches here; such notes are dropped.
    function automatic dur_t quantise_dur(input logic [7:0] count);
        if (count >= 8'd8)
            return DUR_WHOLE;
        else if (count >= 8'd4)
            return DUR_HALF;
        else if (count >= 8'd2)
            return DUR_QUARTER;
        else
            return DUR_EIGHTH;
    endfunction

endpackage

// File: rtl/note_event_tracker_fifo.sv
// note_event_fifo
// Synchronous show-ahead FIFO of note_event_t records.
// Ports:
//   clk_in, rst_in  - clock, synchronous active-low reset
//   i_push, i_data  - write request and record
//   i_ready         - consumer accepts the head this cycle
//   o_valid, o_head - head valid and head record (zero while empty)
//   o_count         - occupancy 0..DEPTH
//   o_overflow      - sticky: a push was lost because the FIFO was full
module note_event_fifo
    import note_event_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  note_event_t                i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output note_event_t                o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    note_event_t     r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic            w_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && i_ready;
    assign w_full  = (r_count == DEPTH_C);
    // When full, a simultaneous pop frees the slot being written.
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk_in) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push && !w_wr)
                r_overflow <= 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid    = w_valid;
    assign o_head     = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/note_event_tracker.sv
// note_event_tracker
// Debounces the per-frame note index stream, measures each stable note in
// metronome eighth ticks, quantises the length and queues {note, duration}
// events for the score renderer.
// Ports:
//   clk_in, rst_in        - clk_m, synchronous active-low reset
//   note_in/note_valid_in - note index sample and its strobe (0 = rest)
//   eighth_tick_in        - metronome eighth-note strobe
//   flush_in              - close the current note and go idle
//   event_*               - show-ahead event FIFO head, valid/ready
//   current_note_out      - committed note
//   fifo_count_out        - FIFO occupancy
//   drop_out              - pulse: a note shorter than an eighth was dropped
//   overflow_out          - sticky: an event was lost to a full FIFO
module note_event_tracker
    import note_event_pkg::*;
#(
    parameter int STABLE_COUNT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_EIGHTHS  = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [5:0] note_in,
    input  logic       note_valid_in,
    input  logic       eighth_tick_in,
    input  logic       flush_in,
    output logic       event_valid_out,
    input  logic       event_ready_in,
    output logic [5:0] event_note_out,
    output logic [1:0] event_dur_out,
    output logic [5:0] current_note_out,
    output logic [3:0] fifo_count_out,
    output logic       drop_out,
    output logic       overflow_out
);

    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam int EW = $clog2(MAX_EIGHTHS + 1);
    localparam logic [MW-1:0] STABLE_C = MW'(STABLE_COUNT);
    localparam logic [EW-1:0] MAX_C    = EW'(MAX_EIGHTHS);

    track_state_t  r_state;
    logic [5:0]    r_cand;
    logic [MW-1:0] r_match;
    logic [5:0]    r_current;
    logic [EW-1:0] r_eighths;
    logic          r_drop;

    logic          w_same;
    logic [5:0]    w_cand_next;
    logic [MW-1:0] w_match_next;
    logic          w_commit;
    logic          w_tick;
    logic [EW-1:0] w_n;
    logic          w_wrap;
    logic          w_close;
    logic          w_push;
    note_event_t   w_push_evt;
    note_event_t   w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    // Debounce: the commit fires only on the sample that reaches the
    // threshold, so a saturated count does not re-commit.
    assign w_same       = (note_in == r_cand);
    assign w_cand_next  = w_same ? r_cand : note_in;
    assign w_match_next = !w_same              ? MW'(1)  :
                          (r_match == STABLE_C) ? r_match : r_match + MW'(1);
    assign w_commit     = note_valid_in
                       && (w_match_next == STABLE_C)
                       && (!w_same || (r_match != STABLE_C))
                       && (w_cand_next != r_current);

    // A tick in the same cycle as a close is credited to the closing note.
    assign w_tick  = eighth_tick_in && (r_state == ST_TRACK);
    assign w_n     = r_eighths + EW'(w_tick);
    assign w_wrap  = (w_n == MAX_C);
    assign w_close = (r_state == ST_TRACK) && (flush_in || w_commit);

    // A wrap coinciding with a close collapses into the single close push.
    always_comb begin
        w_push          = 1'b0;
        w_push_evt.note = r_current;
        w_push_evt.dur  = DUR_WHOLE;
        if (w_close) begin
            w_push         = (w_n != '0);
            w_push_evt.dur = w_wrap ? DUR_WHOLE : quantise_dur(8'(w_n));
        end else if (w_wrap) begin
            w_push = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= ST_IDLE;
            r_cand    <= '0;
            r_match   <= '0;
            r_current <= REST_NOTE;
            r_eighths <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_close && (w_n == '0);
            if (note_valid_in) begin
                r_cand  <= w_cand_next;
                r_match <= w_match_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_commit) begin
                        r_state   <= ST_TRACK;
                        r_current <= w_cand_next;
                        r_eighths <= '0;
                    end
                end
                ST_TRACK: begin
                    // flush wins; the commit is lost but the candidate stays
                    if (flush_in) begin
                        r_state   <= ST_IDLE;
                        r_current <= REST_NOTE;
                        r_eighths <= '0;
                    end else if (w_commit) begin
                        r_current <= w_cand_next;
                        r_eighths <= '0;
                    end else if (w_wrap) begin
                        r_eighths <= '0;
                    end else begin
                        r_eighths <= w_n;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    note_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_push     (w_push),
        .i_data     (w_push_evt),
        .i_ready    (event_ready_in),
        .o_valid    (event_valid_out),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_overflow (overflow_out)
    );

    assign event_note_out   = w_head.note;
    assign event_dur_out    = w_head.dur;
    assign current_note_out = r_current;
    assign fifo_count_out   = 4'(w_count);
    assign drop_out         = r_drop;

endmodule
